// File: rtl/chunk_serial_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding and the
// WIDTH/CHUNK legality test used at elaboration.
`ifndef CSA_LEGAL
`define CSA_LEGAL(W, C) ((((W) % (C)) == 0) && ((C) >= 1) && ((C) <= (W)))
`endif

package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_serial_adder_cla_chunk.sv
// Combinational CHUNK-bit carry-lookahead slice; c_msb is the carry into
// the top bit so the caller can form signed overflow.
module cla_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products over generate/propagate terms,
  // so no carry depends on another carry.
  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= CHUNK; i++) begin
      term = cin;
      for (int k = 0; k < i; k++) term = term & p[k];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
  end

  assign sum   = p ^ c[CHUNK-1:0];
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// Area-optimised WIDTH-bit adder/subtractor: one CHUNK-bit CLA slice reused
// over WIDTH/CHUNK cycles, LSB chunk first, with a start/ready/done handshake.
`ifndef CSA_LEGAL
`define CSA_LEGAL(W, C) ((((W) % (C)) == 0) && ((C) >= 1) && ((C) <= (W)))
`endif

module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = num_chunks(WIDTH, CHUNK);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!`CSA_LEGAL(WIDTH, CHUNK)) begin : g_illegal_geometry
    $error("chunk_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        base;
  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic [CHUNK-1:0]   slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;
  logic               last_chunk;

  assign base       = 32'(cnt_q) * 32'(CHUNK);
  assign slice_a    = a_q[base +: CHUNK];
  assign slice_b    = b_q[base +: CHUNK];
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  cla_chunk #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1; the +1 rides in on the carry register.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = slice_sum;
        carry_d              = slice_cout;
        cnt_d                = cnt_q + 1'b1;
        if (last_chunk) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand registers are only meaningful after an accept, so no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Scoreboard bench for chunk_serial_adder at WIDTH=16, CHUNK=4: stimulus
// queues expected results, a monitor checks every done pulse and handshake.
module tb_chunk_serial_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   stim_done;

  chunk_serial_adder #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic op(input logic s, input logic ci, input logic [W-1:0] aa, input logic [W-1:0] bb,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    @(posedge clk); #2;
    start = 1'b1; sub = s; cin = ci; a = aa; b = bb;
    e.sum = es; e.cout = ec; e.ovf = eo;
    exp_q.push_back(e);
    @(posedge clk); #2;
    start = 1'b0; sub = ~s; cin = ~ci; a = 16'hDEAD; b = 16'hBEEF;
    repeat (N + 1) @(posedge clk);
  endtask

  // Stimulus
  initial begin
    exp_t e;
    stim_done = 1'b0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    op(1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
    op(1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    op(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
    op(1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    op(1'b1, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    op(1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    op(1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    op(1'b0, 1'b1, 16'h0F0F, 16'h00F0, 16'h1000, 1'b0, 1'b0);

    // Start pulsed during RUN must be dropped.
    @(posedge clk); #2;
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 16'h0001; b = 16'h0001;
    e.sum = 16'h0002; e.cout = 1'b0; e.ovf = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #2;
    a = 16'hAAAA; b = 16'hAAAA;
    repeat (2) @(posedge clk);
    #2 start = 1'b0;
    repeat (N + 2) @(posedge clk);

    // Reset in the second RUN cycle aborts with no done.
    @(posedge clk); #2;
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 16'h4444; b = 16'h1111;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (N + 4) @(posedge clk);

    op(1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    stim_done = 1'b1;
  end

  // Monitor: samples on the falling edge, between input updates.
  initial begin
    exp_t e;
    bit   prev_rst;
    bit   prev_accept;
    bit   in_op;
    bit   tracking;
    bit   have_result;
    int   lat;
    int   ready_low;
    logic [W-1:0] last_sum;
    checks = 0; errors = 0;
    prev_rst = 1'b0; prev_accept = 1'b0; in_op = 1'b0; tracking = 1'b0;
    have_result = 1'b0; lat = 0; ready_low = 0; last_sum = '0;
    while (!stim_done) begin
      @(negedge clk);
      if (prev_rst) begin
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_flags", {30'd0, cout, overflow}, 32'd0);
        in_op = 1'b0; tracking = 1'b0;
        have_result = 1'b1; last_sum = '0;
      end else begin
        if (prev_accept) begin
          in_op = 1'b1; lat = 0; tracking = 1'b1; ready_low = 0;
        end else if (in_op) begin
          lat++;
        end
        if (tracking) begin
          if (!ready) ready_low++;
          else begin
            chk("ready_low_cycles", 32'(ready_low), 32'(N + 1));
            tracking = 1'b0;
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_latency", 32'(lat), 32'(N));
            chk("sum", 32'(sum), 32'(e.sum));
            chk("cout", 32'(cout), 32'(e.cout));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            last_sum = e.sum; have_result = 1'b1;
          end
          in_op = 1'b0;
        end else if (ready && have_result) begin
          chk("sum_hold", 32'(sum), 32'(last_sum));
        end
      end
      prev_rst    = !rst_n;
      prev_accept = rst_n && ready && start;
    end
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

- Multi-cycle, parametrised WIDTH-bit adder/subtractor; generalises the single-bit half adder to full operand width, carry-in and subtract mode.
- Processes operands CHUNK bits per clock, least-significant chunk first, through one CHUNK-bit carry-lookahead slice, keeping the carry in a register between cycles.
- Sits beside the ALU datapath as the area-optimised adder: a start/ready/done handshake, with signed overflow and carry-out flags.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8: bits processed per cycle, 1..WIDTH; N = WIDTH/CHUNK cycles per operation.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only on an edge where ready=1.
- sub  in  1  0: a+b+cin; 1: a+~b+1 (a-b), cin ignored.
- cin  in  1  carry-in for add mode.
- a  in  WIDTH  operand A, sampled at accept.
- b  in  WIDTH  operand B, sampled at accept.
- ready  out  1  block idle, able to accept start.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result; stable from done until next accept.
- cout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow (carry into MSB xor carry out of MSB).

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, ready=1, done=0;
  - sum=0, cout=0, overflow=0;
  - chunk counter=0, carry register=0.
- Reset mid-RUN aborts the operation with no done pulse.
- IDLE:
  - ready=1.
  - On start=1, capture a into A_reg and b_eff = sub ? ~b : b into B_reg.
  - Carry register = sub ? 1 : cin.
  - Counter=0. Go to RUN.
- RUN:
  - ready=0.
  - Each cycle, slice i = counter adds A_reg[i*CHUNK +: CHUNK] + B_reg[...] + carry.
  - Writes sum[i*CHUNK +: CHUNK], updates carry, increments counter.
  - On the last chunk (counter = N-1), also register:
    - cout = carry out of the slice;
    - overflow = carry into bit WIDTH-1 xor carry out.
  - Then go to DONE.
- DONE:
  - done=1, ready=0 for exactly one cycle, then go to IDLE.
- Inputs a, b, sub, cin are ignored outside the accept edge; start in RUN/DONE is dropped, not queued.
- During RUN, sum holds a mix of new and stale chunks; it is valid only from done onward.
- sum, cout and overflow hold their values in IDLE until the next accept.
- Arithmetic is modulo 2^WIDTH; cout in sub mode is the not-borrow (1 when a >= b unsigned).

## Timing
- Accept edge E0: state→RUN.
- Chunks are computed at edges E1..EN; DONE is entered at EN.
- done=1 in the cycle after EN; ready=1 again after edge EN+1.
- Latency from accept to done: N cycles. Minimum issue interval: N+2 cycles.
- N=1 (CHUNK=WIDTH): single RUN cycle, done after E1.
- CHUNK=1: bit-serial.
- Critical path is one CHUNK-bit CLA plus the carry mux; independent of WIDTH.

## Structure
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the WIDTH % CHUNK legality check macro.
- Sub-module cla_chunk, parametrised by CHUNK:
  - purely combinational carry-lookahead slice;
  - per-bit generate/propagate and group carries;
  - ports a, b, cin, sum, cout, plus c_msb (carry into top bit) for overflow.
- Top level holds the FSM, counter, operand and carry registers, and the chunk-select/write-back muxing.

## Test plan
All cases use WIDTH=16, CHUNK=4.
- Add, cin=0: a=0x1234, b=0x4321 -> sum=0x5555, cout=0, overflow=0. done exactly 4 cycles after the accept edge; ready low for 5 cycles.
- Carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Also a=0xFFFF, b=0x0000, cin=1 -> same result.
- Subtract: sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1. Also a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Busy start: accept a=0x0001, b=0x0001. Then pulse start in RUN with a=0xAAAA -> ignored; sum=0x0002; one done pulse only.
- Reset mid-op: assert rst_n=0 in the 2nd RUN cycle. After that edge: ready=1, done=0, sum=0, and no done follows. A following 0x00FF+0x0001 gives 0x0100.
